// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divisor and frame-length
// helpers. The RX side reuses the same helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_state_t;

  // Rounded-to-nearest clock cycles per line bit.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  function automatic int frame_len(input int data_bits, input int parity_en,
                                   input int stop_bits, input int cpb);
    return (1 + data_bits + parity_en + stop_bits) * cpb;
  endfunction

  localparam int DEF_CPB   = clks_per_bit(50_000_000, 115_200);
  localparam int FRAME_LEN = frame_len(8, 0, 1, DEF_CPB);

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. clear holds the count at zero between frames.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)     cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops bytes from the ring buffer read port and
// serializes them. All outputs are decoded from registered state only.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic                 fifo_rd_valid,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int IW  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  uart_state_t          state, state_nx;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 tick, baud_clear;

  // Baud count only runs while a frame is on the line; WAIT clears it so
  // START begins on a full bit period.
  assign baud_clear = (state == ST_IDLE) || (state == ST_FETCH) || (state == ST_WAIT);

  uart_baud_gen #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_nx = state;
    shift_d  = shift_q;
    idx_d    = idx_q;
    par_d    = par_q;
    tx       = 1'b1;
    tx_done  = 1'b0;
    case (state)
      ST_IDLE:  if (enable && !fifo_empty) state_nx = ST_FETCH;
      ST_FETCH: state_nx = ST_WAIT;
      ST_WAIT: begin
        // No valid means the empty flag lagged; drop back quietly.
        if (fifo_rd_valid) begin
          shift_d  = fifo_rd_data;
          par_d    = (^fifo_rd_data) ^ (PARITY_ODD != 0);
          idx_d    = '0;
          state_nx = ST_START;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (tick) begin
          idx_d    = '0;
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        tx = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_DATA) begin
            idx_d    = '0;
            state_nx = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        tx = par_q;
        if (tick) state_nx = ST_STOP;
      end
      ST_STOP: begin
        // idx_q counts stop bits here.
        if (tick) begin
          if (idx_q == LAST_STOP) begin
            tx_done  = 1'b1;
            idx_d    = '0;
            state_nx = ST_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign fifo_rd_en = (state == ST_FETCH);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: three configurations (8N1, 8E1, 8O2) fed by a
// small ring-buffer model; tx is compared cycle by cycle to ideal frames.
module tb_uart_tx_drain;
  localparam int N   = 3;
  localparam int CPB = 16;
  localparam int LW  = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0] enable, empty, rd_en, rd_valid, tx, busy, done;
  logic [N-1:0] withhold;
  logic [7:0]   rd_data [N];

  // Ring buffer model: pop returns data one cycle later. With withhold set the
  // byte is consumed but valid never rises, as when the empty flag lagged.
  logic [7:0] mem [N][16];
  int wp [N] = '{0, 0, 0};
  int rp [N] = '{0, 0, 0};

  for (genvar g = 0; g < N; g++) begin : g_empty
    assign empty[g] = (wp[g] == rp[g]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      rd_valid[i] <= 1'b0;
      if (rd_en[i] && wp[i] != rp[i]) begin
        rd_data[i]  <= mem[i][rp[i] % 16];
        rd_valid[i] <= !withhold[i];
        rp[i]       <= rp[i] + 1;
      end
    end
  end

  uart_tx_drain #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8), .PARITY_EN(0),
                  .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .enable(enable[0]), .fifo_empty(empty[0]),
    .fifo_rd_en(rd_en[0]), .fifo_rd_valid(rd_valid[0]), .fifo_rd_data(rd_data[0]),
    .tx(tx[0]), .busy(busy[0]), .tx_done(done[0]));

  uart_tx_drain #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8), .PARITY_EN(1),
                  .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable[1]), .fifo_empty(empty[1]),
    .fifo_rd_en(rd_en[1]), .fifo_rd_valid(rd_valid[1]), .fifo_rd_data(rd_data[1]),
    .tx(tx[1]), .busy(busy[1]), .tx_done(done[1]));

  uart_tx_drain #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8), .PARITY_EN(1),
                  .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable[2]), .fifo_empty(empty[2]),
    .fifo_rd_en(rd_en[2]), .fifo_rd_valid(rd_valid[2]), .fifo_rd_data(rd_data[2]),
    .tx(tx[2]), .busy(busy[2]), .tx_done(done[2]));

  // Per-cycle log of outputs, sampled on the falling edge.
  int   cyc = 0;
  logic txl [N][LW];
  logic dnl [N][LW];
  logic rdl [N][LW];
  logic bsl [N][LW];

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      txl[i][cyc % LW] <= tx[i];
      dnl[i][cyc % LW] <= done[i];
      rdl[i][cyc % LW] <= rd_en[i];
      bsl[i][cyc % LW] <= busy[i];
    end
    cyc <= cyc + 1;
  end

  // Reference: ideal line levels per cycle and the cycles where tx_done fires.
  logic exp_q [$];
  int   exp_done [$];
  int   tests = 0;
  int   fails = 0;

  function automatic void exp_clear();
    exp_q.delete();
    exp_done.delete();
  endfunction

  function automatic void exp_idle(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endfunction

  function automatic void exp_frame(input logic [7:0] b, input bit pen,
                                    input bit podd, input int stops);
    logic lv [$];
    lv.push_back(1'b0);
    for (int k = 0; k < 8; k++) lv.push_back(b[k]);
    if (pen) lv.push_back((^b) ^ podd);
    for (int k = 0; k < stops; k++) lv.push_back(1'b1);
    foreach (lv[k]) repeat (CPB) exp_q.push_back(lv[k]);
    exp_done.push_back(exp_q.size() - 1);
  endfunction

  function automatic int tx_diff(input int i, input int t0);
    int d = 0;
    foreach (exp_q[k]) if (txl[i][(t0 + k) % LW] !== exp_q[k]) d++;
    return d;
  endfunction

  function automatic int done_diff(input int i, input int t0);
    int d = 0;
    foreach (exp_q[k]) begin
      logic e = 1'b0;
      foreach (exp_done[j]) if (exp_done[j] == k) e = 1'b1;
      if (dnl[i][(t0 + k) % LW] !== e) d++;
    end
    return d;
  endfunction

  function automatic int rd_count(input int i, input int t0, input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (rdl[i][(t0 + k) % LW] === 1'b1) c++;
    return c;
  endfunction

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] b);
    mem[i][wp[i] % 16] = b;
    wp[i] = wp[i] + 1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    run(2);
    tests++; if (tx !== 3'b111) begin fails++; $display("FAIL reset_tx: got %b expected 111", tx); end
    tests++; if (busy !== 3'b000) begin fails++; $display("FAIL reset_busy: got %b expected 000", busy); end
    tests++; if (rd_en !== 3'b000) begin fails++; $display("FAIL reset_rd_en: got %b expected 000", rd_en); end
    tests++; if (done !== 3'b000) begin fails++; $display("FAIL reset_done: got %b expected 000", done); end
    rst = 1'b0;
    enable = '1;
    run(2);
  endtask

  task automatic test_single;
    int t0, d;
    exp_clear();
    t0 = cyc;
    push(0, 8'h55);
    exp_idle(3); exp_frame(8'h55, 0, 0, 1); exp_idle(10);
    run(exp_q.size());
    tests++; if (txl[0][(t0 + 2) % LW] !== 1'b1 || txl[0][(t0 + 3) % LW] !== 1'b0) begin
      fails++; $display("FAIL single_latency: got %b%b expected 10", txl[0][(t0 + 2) % LW], txl[0][(t0 + 3) % LW]);
    end
    d = tx_diff(0, t0);
    tests++; if (d != 0) begin fails++; $display("FAIL single_tx: %0d cycles differ, expected 0", d); end
    d = done_diff(0, t0);
    tests++; if (d != 0) begin fails++; $display("FAIL single_done: %0d cycles differ, expected 0", d); end
    d = rd_count(0, t0, exp_q.size());
    tests++; if (d != 1) begin fails++; $display("FAIL single_rd_en: got %0d pops expected 1", d); end
  endtask

  task automatic test_back_to_back;
    int t0, d;
    logic [7:0] got;
    exp_clear();
    t0 = cyc;
    push(0, 8'hA3); push(0, 8'h0F);
    exp_idle(3); exp_frame(8'hA3, 0, 0, 1); exp_idle(3); exp_frame(8'h0F, 0, 0, 1); exp_idle(8);
    run(exp_q.size());
    d = tx_diff(0, t0);
    tests++; if (d != 0) begin fails++; $display("FAIL b2b_tx: %0d cycles differ, expected 0", d); end
    d = done_diff(0, t0);
    tests++; if (d != 0) begin fails++; $display("FAIL b2b_done: %0d cycles differ, expected 0", d); end
    d = rd_count(0, t0, exp_q.size());
    tests++; if (d != 2) begin fails++; $display("FAIL b2b_rd_en: got %0d pops expected 2", d); end
    tests++; if (txl[0][(t0 + 165) % LW] !== 1'b1 || txl[0][(t0 + 166) % LW] !== 1'b0) begin
      fails++; $display("FAIL b2b_gap: got %b%b expected 10", txl[0][(t0 + 165) % LW], txl[0][(t0 + 166) % LW]);
    end
    // Mid-bit sampling, as a receiver would.
    for (int k = 0; k < 8; k++) got[k] = txl[0][(t0 + 3 + CPB * (k + 1) + 8) % LW];
    tests++; if (got !== 8'hA3) begin fails++; $display("FAIL b2b_byte0: got %h expected a3", got); end
    for (int k = 0; k < 8; k++) got[k] = txl[0][(t0 + 166 + CPB * (k + 1) + 8) % LW];
    tests++; if (got !== 8'h0F) begin fails++; $display("FAIL b2b_byte1: got %h expected 0f", got); end
  endtask

  task automatic test_parity;
    int t0, d, hi;
    t0 = cyc;
    push(1, 8'h07); push(2, 8'h07);
    run(199);
    exp_clear(); exp_idle(3); exp_frame(8'h07, 1, 0, 1); exp_idle(20);
    d = tx_diff(1, t0);
    tests++; if (d != 0) begin fails++; $display("FAIL even_tx: %0d cycles differ, expected 0", d); end
    d = done_diff(1, t0);
    tests++; if (d != 0) begin fails++; $display("FAIL even_done: %0d cycles differ, expected 0", d); end
    tests++; if (txl[1][(t0 + 3 + 144 + 8) % LW] !== 1'b1) begin
      fails++; $display("FAIL even_parity_bit: got %b expected 1", txl[1][(t0 + 155) % LW]);
    end
    exp_clear(); exp_idle(3); exp_frame(8'h07, 1, 1, 2); exp_idle(4);
    d = tx_diff(2, t0);
    tests++; if (d != 0) begin fails++; $display("FAIL odd2_tx: %0d cycles differ, expected 0", d); end
    d = done_diff(2, t0);
    tests++; if (d != 0) begin fails++; $display("FAIL odd2_done: %0d cycles differ, expected 0", d); end
    tests++; if (txl[2][(t0 + 3 + 144 + 8) % LW] !== 1'b0) begin
      fails++; $display("FAIL odd_parity_bit: got %b expected 0", txl[2][(t0 + 155) % LW]);
    end
    hi = 0;
    for (int k = 0; k < 32; k++) if (txl[2][(t0 + 3 + 160 + k) % LW] === 1'b1) hi++;
    tests++; if (hi != 32) begin fails++; $display("FAIL two_stop_high: got %0d high cycles expected 32", hi); end
  endtask

  task automatic test_no_valid;
    int t0, lows, dn;
    withhold[0] = 1'b1;
    t0 = cyc;
    push(0, 8'h99);
    run(20);
    withhold[0] = 1'b0;
    lows = 0; dn = 0;
    for (int k = 0; k < 20; k++) begin
      if (txl[0][(t0 + k) % LW] !== 1'b1) lows++;
      if (dnl[0][(t0 + k) % LW] !== 1'b0) dn++;
    end
    tests++; if (lows != 0) begin fails++; $display("FAIL novalid_tx: got %0d non-high cycles expected 0", lows); end
    tests++; if (dn != 0) begin fails++; $display("FAIL novalid_done: got %0d pulses expected 0", dn); end
    tests++; if (bsl[0][(t0 + 2) % LW] !== 1'b1 || bsl[0][(t0 + 3) % LW] !== 1'b0) begin
      fails++; $display("FAIL novalid_idle: busy got %b%b expected 10", bsl[0][(t0 + 2) % LW], bsl[0][(t0 + 3) % LW]);
    end
    lows = rd_count(0, t0, 20);
    tests++; if (lows != 1) begin fails++; $display("FAIL novalid_rd_en: got %0d pops expected 1", lows); end
  endtask

  task automatic test_reset_mid;
    int t0, dn, d;
    t0 = cyc;
    push(0, 8'hFF);
    run(72);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(20);
    tests++; if (bsl[0][(t0 + 72) % LW] !== 1'b1 || bsl[0][(t0 + 73) % LW] !== 1'b0) begin
      fails++; $display("FAIL rstmid_busy: got %b%b expected 10", bsl[0][(t0 + 72) % LW], bsl[0][(t0 + 73) % LW]);
    end
    tests++; if (txl[0][(t0 + 73) % LW] !== 1'b1) begin
      fails++; $display("FAIL rstmid_tx: got %b expected 1", txl[0][(t0 + 73) % LW]);
    end
    dn = 0;
    for (int k = 0; k < 93; k++) if (dnl[0][(t0 + k) % LW] !== 1'b0) dn++;
    tests++; if (dn != 0) begin fails++; $display("FAIL rstmid_done: got %0d pulses expected 0", dn); end
    exp_clear();
    t0 = cyc;
    push(0, 8'h12);
    exp_idle(3); exp_frame(8'h12, 0, 0, 1); exp_idle(5);
    run(exp_q.size());
    d = tx_diff(0, t0);
    tests++; if (d != 0) begin fails++; $display("FAIL rstmid_next_tx: %0d cycles differ, expected 0", d); end
    d = done_diff(0, t0);
    tests++; if (d != 0) begin fails++; $display("FAIL rstmid_next_done: %0d cycles differ, expected 0", d); end
  endtask

  task automatic test_enable;
    int t0, d;
    exp_clear();
    t0 = cyc;
    push(0, 8'h81); push(0, 8'h22); push(0, 8'h33);
    run(4);
    enable[0] = 1'b0;
    run(216);
    exp_idle(3); exp_frame(8'h81, 0, 0, 1); exp_idle(57);
    d = tx_diff(0, t0);
    tests++; if (d != 0) begin fails++; $display("FAIL en_off_tx: %0d cycles differ, expected 0", d); end
    d = done_diff(0, t0);
    tests++; if (d != 0) begin fails++; $display("FAIL en_off_done: %0d cycles differ, expected 0", d); end
    d = rd_count(0, t0, 220);
    tests++; if (d != 1) begin fails++; $display("FAIL en_off_rd_en: got %0d pops expected 1", d); end
    exp_clear();
    t0 = cyc;
    enable[0] = 1'b1;
    exp_idle(3); exp_frame(8'h22, 0, 0, 1); exp_idle(3); exp_frame(8'h33, 0, 0, 1); exp_idle(5);
    run(exp_q.size());
    d = tx_diff(0, t0);
    tests++; if (d != 0) begin fails++; $display("FAIL en_on_tx: %0d cycles differ, expected 0", d); end
    d = rd_count(0, t0, exp_q.size());
    tests++; if (d != 2) begin fails++; $display("FAIL en_on_rd_en: got %0d pops expected 2", d); end
  endtask

  // Random bytes across all three configurations at once.
  task automatic test_random;
    int t0, d;
    logic [7:0] b [N];
    for (int r = 0; r < 3; r++) begin
      t0 = cyc;
      for (int i = 0; i < N; i++) begin
        b[i] = 8'($urandom_range(0, 255));
        push(i, b[i]);
      end
      run(200);
      exp_clear(); exp_idle(3); exp_frame(b[0], 0, 0, 1); exp_idle(37);
      d = tx_diff(0, t0);
      tests++; if (d != 0) begin fails++; $display("FAIL rand_8n1 byte %h: %0d cycles differ, expected 0", b[0], d); end
      exp_clear(); exp_idle(3); exp_frame(b[1], 1, 0, 1); exp_idle(21);
      d = tx_diff(1, t0);
      tests++; if (d != 0) begin fails++; $display("FAIL rand_8e1 byte %h: %0d cycles differ, expected 0", b[1], d); end
      exp_clear(); exp_idle(3); exp_frame(b[2], 1, 1, 2); exp_idle(5);
      d = tx_diff(2, t0);
      tests++; if (d != 0) begin fails++; $display("FAIL rand_8o2 byte %h: %0d cycles differ, expected 0", b[2], d); end
      d = done_diff(2, t0);
      tests++; if (d != 0) begin fails++; $display("FAIL rand_8o2_done: %0d cycles differ, expected 0", d); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    enable   = '0;
    withhold = '0;
    run(3);
    test_reset;
    test_single;
    test_back_to_back;
    test_parity;
    test_no_valid;
    test_reset_mid;
    test_enable;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
